// File: rtl/gelu_vec_serializer_pkg.sv
// Shared constants and types for the GELU vector serializer.
// Lane geometry matches the NN-LUT GELU stage that feeds this block.
package gelu_vec_serializer_pkg;

  localparam int DIMENTION  = 64;  // lanes per GELU vector
  localparam int DATA_WIDTH = 8;   // bits per lane, signed, passed through untouched
  localparam int CHUNK      = 16;  // lanes per output beat
  localparam int FIFO_DEPTH = 4;   // vectors buffered (power of 2, >= 2)

  localparam int BEATS   = DIMENTION / CHUNK;
  localparam int VEC_W   = DIMENTION * DATA_WIDTH;
  localparam int CHUNK_W = CHUNK * DATA_WIDTH;
  localparam int BEAT_W  = $clog2(BEATS);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  typedef logic [VEC_W-1:0]   vec_t;
  typedef logic [CHUNK_W-1:0] chunk_t;

  // Output FSM: idle, or streaming the beats of the FIFO head.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/gelu_vec_serializer_if.sv
// Vector input and beat output bundle of the GELU vector serializer.
//
// Handshakes:
//  - Input side: gelu_valid_n low means gelu_in holds one vector this cycle.
//    There is no backpressure; a vector that cannot be stored is dropped.
//  - Output side: a beat transfers on a rising edge where out_valid && out_ready.
//    Once out_valid is high it stays high, and out_data/out_last/out_beat_idx
//    stay constant, until that transfer happens (reset excepted).
interface gelu_vec_serializer_if;
  import gelu_vec_serializer_pkg::*;

  logic [VEC_W-1:0]   gelu_in;
  logic               gelu_valid_n;
  logic [CHUNK_W-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [BEAT_W-1:0]  out_beat_idx;

  // Serializer side
  modport master (
    input  gelu_in, gelu_valid_n, out_ready,
    output out_data, out_valid, out_last, out_beat_idx
  );

  // Environment side: GELU producer plus downstream consumer
  modport slave (
    output gelu_in, gelu_valid_n, out_ready,
    input  out_data, out_valid, out_last, out_beat_idx
  );

endinterface

// File: rtl/nnlut_vec_fifo.sv
// Synchronous vector FIFO with registered storage.
// The head entry is always visible on dout; push and pop may share an edge.
// The caller must not push when full without popping, nor pop when empty.
module nnlut_vec_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic                       clk_p,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is data only; validity is tracked by the pointers and level.
  always_ff @(posedge clk_p) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/gelu_vec_serializer.sv
// Captures GELU result vectors into a small FIFO and streams each one out as
// BEATS chunk beats over valid/ready. Lane 0 sits in the MSBs of both the
// input vector and the first beat; lane data is passed through bit-exact.
module gelu_vec_serializer
  import gelu_vec_serializer_pkg::*;
(
  input  logic                clk_p,
  input  logic                rst_n,
  gelu_vec_serializer_if.master bus,
  input  logic                clr_overflow,
  output logic [LEVEL_W-1:0]  fifo_level,
  output logic                overflow,
  output state_t              state_dbg
);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  vec_t              head;
  chunk_t            chunk;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_req;
  logic              last_beat;
  logic              pop;
  logic              push;

  assign wr_req    = !bus.gelu_valid_n;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  // The head leaves the FIFO only when its final beat is accepted.
  assign pop       = (state_q == ST_STREAM) && bus.out_ready && last_beat;
  // A full FIFO still accepts when the head pops on the same edge.
  assign push      = wr_req && (!fifo_full || pop);
  assign state_dbg = state_q;

  nnlut_vec_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_p (clk_p),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.gelu_in),
    .pop   (pop),
    .dout  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Chunk mux: beat b carries lanes b*CHUNK .. b*CHUNK+CHUNK-1, first lane in MSBs.
  always_comb begin
    chunk = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) chunk = head[VEC_W-1-b*CHUNK_W -: CHUNK_W];
    end
  end

  // FSM state and beat counter registers.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state and beat outputs; outputs are decoded from registered state only.
  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    bus.out_valid    = 1'b0;
    bus.out_data     = '0;
    bus.out_last     = 1'b0;
    bus.out_beat_idx = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_STREAM;
          beat_d  = '0;
        end
      end
      ST_STREAM: begin
        bus.out_valid = 1'b1;
        bus.out_data  = chunk;
        bus.out_last  = last_beat;
        if (bus.out_ready) begin
          if (last_beat) begin
            beat_d = '0;
            // Continue without a bubble if another vector is (or is becoming) the head.
            if (fifo_level > LEVEL_W'(1) || push) state_d = ST_STREAM;
            else                                  state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Sticky drop flag; a drop on the same edge as a clear wins.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n)                overflow <= 1'b0;
    else if (wr_req && !push)  overflow <= 1'b1;
    else if (clr_overflow)     overflow <= 1'b0;
  end

endmodule

// File: tb/tb_gelu_vec_serializer.sv
// Directed bench for gelu_vec_serializer: single vector, backpressure,
// back-to-back vectors, overflow/clear, full+pop and mid-vector reset.
module tb_gelu_vec_serializer;
  import gelu_vec_serializer_pkg::*;

  // ---------------- clock / reset ----------------
  logic               clk_p = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr_overflow = 1'b0;
  logic [LEVEL_W-1:0] fifo_level;
  logic               overflow;
  state_t             state_dbg;

  gelu_vec_serializer_if bus ();

  always #5 clk_p = ~clk_p;

  gelu_vec_serializer dut (
    .clk_p        (clk_p),
    .rst_n        (rst_n),
    .bus          (bus),
    .clr_overflow (clr_overflow),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int                 n_assert = 0;
  int                 n_fail   = 0;
  logic [CHUNK_W-1:0] exp_q[$];
  logic [BEAT_W-1:0]  exp_idx_q[$];

  task automatic chk(input string tag, input logic [CHUNK_W-1:0] obs,
                     input logic [CHUNK_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Vector whose lane i holds base+i (mod 256), lane 0 in the MSBs.
  function automatic vec_t make_vec(input logic [7:0] base);
    vec_t v;
    v = '0;
    for (int i = 0; i < DIMENTION; i++) v[VEC_W-1-8*i -: 8] = 8'(base + i);
    return v;
  endfunction

  // Beat b of such a vector, built lane by lane by shifting in from the right.
  function automatic logic [CHUNK_W-1:0] exp_beat(input logic [7:0] base, input int b);
    logic [CHUNK_W-1:0] r;
    r = '0;
    for (int j = 0; j < CHUNK; j++) r = {r[CHUNK_W-9:0], 8'(base + b*CHUNK + j)};
    return r;
  endfunction

  task automatic expect_vec(input logic [7:0] base);
    for (int b = 0; b < BEATS; b++) begin
      exp_q.push_back(exp_beat(base, b));
      exp_idx_q.push_back(BEAT_W'(b));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input logic [7:0] base);
    bus.gelu_in      = make_vec(base);
    bus.gelu_valid_n = 1'b0;
  endtask

  task automatic drive_idle();
    bus.gelu_valid_n = 1'b1;
    bus.gelu_in      = '0;
  endtask

  task automatic step();
    @(negedge clk_p);
  endtask

  // Compare the beat on the bus with the scoreboard head; retire it if it transfers.
  task automatic check_beat(input string tag);
    chk_s({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk_s({tag, ".pending"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      chk({tag, ".data"}, bus.out_data, exp_q[0]);
      chk_s({tag, ".idx"}, 32'(bus.out_beat_idx), 32'(exp_idx_q[0]));
      chk_s({tag, ".last"}, 32'(bus.out_last), 32'(exp_idx_q[0] == BEAT_W'(BEATS-1)));
      if (bus.out_ready) begin
        void'(exp_q.pop_front());
        void'(exp_idx_q.pop_front());
      end
    end
  endtask

  task automatic check_status(input string tag, input logic valid, input int level,
                              input logic ovf);
    chk_s({tag, ".valid"}, 32'(bus.out_valid), 32'(valid));
    chk_s({tag, ".level"}, 32'(fifo_level), 32'(level));
    chk_s({tag, ".ovf"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic check_all_zero(input string tag);
    chk_s({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".data"}, bus.out_data, '0);
    chk_s({tag, ".last"}, 32'(bus.out_last), 32'd0);
    chk_s({tag, ".idx"}, 32'(bus.out_beat_idx), 32'd0);
    chk_s({tag, ".level"}, 32'(fifo_level), 32'd0);
    chk_s({tag, ".ovf"}, 32'(overflow), 32'd0);
    chk_s({tag, ".state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] bases [4];

  initial begin
    bus.out_ready = 1'b1;
    drive_idle();

    // Reset state
    step();
    check_all_zero("rst");
    step();
    rst_n = 1'b1;
    step();

    // 1: single vector, lanes 0x00..0x3F
    drive_vec(8'h00);
    expect_vec(8'h00);
    step();
    drive_idle();
    check_status("t1.entry", 1'b0, 1, 1'b0);
    step();
    chk("t1.beat0_lit", bus.out_data, 128'h000102030405060708090a0b0c0d0e0f);
    check_beat("t1.b0"); step();
    check_beat("t1.b1"); step();
    check_beat("t1.b2"); step();
    chk("t1.beat3_lit", bus.out_data, 128'h303132333435363738393a3b3c3d3e3f);
    check_beat("t1.b3"); step();
    check_status("t1.done", 1'b0, 0, 1'b0);
    chk_s("t1.state", 32'(state_dbg), 32'(ST_IDLE));

    // 2: backpressure for 5 cycles during beat 1
    drive_vec(8'h40);
    expect_vec(8'h40);
    step();
    drive_idle();
    step();
    check_beat("t2.b0"); step();
    bus.out_ready = 1'b0;
    check_beat("t2.stall0");
    for (int k = 0; k < 5; k++) begin
      step();
      chk_s("t2.hold_valid", 32'(bus.out_valid), 32'd1);
      chk_s("t2.hold_idx", 32'(bus.out_beat_idx), 32'd1);
      chk("t2.hold_data", bus.out_data, exp_q[0]);
    end
    bus.out_ready = 1'b1;
    check_beat("t2.b1"); step();
    check_beat("t2.b2"); step();
    check_beat("t2.b3"); step();
    check_status("t2.done", 1'b0, 0, 1'b0);

    // 3: four vectors back to back, 16 beats with no bubble
    bases[0] = 8'h05; bases[1] = 8'h47; bases[2] = 8'h89; bases[3] = 8'hc3;
    for (int v = 0; v < 4; v++) begin
      drive_vec(bases[v]);
      expect_vec(bases[v]);
      if (v >= 2) check_beat("t3.early");
      step();
    end
    drive_idle();
    check_status("t3.full", 1'b1, 4, 1'b0);
    for (int k = 0; k < 14; k++) begin
      check_beat("t3.beat");
      step();
    end
    check_status("t3.done", 1'b0, 0, 1'b0);

    // 4: overflow with the consumer stalled
    bus.out_ready = 1'b0;
    bases[0] = 8'h11; bases[1] = 8'h22; bases[2] = 8'h33; bases[3] = 8'h44;
    for (int v = 0; v < 5; v++) begin
      if (v < 4) begin
        drive_vec(bases[v]);
        expect_vec(bases[v]);
      end else begin
        drive_vec(8'h55);
      end
      step();
    end
    drive_idle();
    check_status("t4.drop", 1'b1, 4, 1'b1);
    check_beat("t4.head");
    drive_vec(8'h66);
    clr_overflow = 1'b1;
    step();
    drive_idle();
    clr_overflow = 1'b0;
    check_status("t4.set_wins", 1'b1, 4, 1'b1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check_status("t4.cleared", 1'b1, 4, 1'b0);

    // 5: full FIFO, new vector on the head's last-beat pop
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_beat("t5.head");
      step();
    end
    drive_vec(8'h2a);
    expect_vec(8'h2a);
    check_beat("t5.pop");
    step();
    drive_idle();
    check_status("t5.level", 1'b1, 4, 1'b0);
    for (int k = 0; k < 16; k++) begin
      check_beat("t5.drain");
      step();
    end
    check_status("t5.done", 1'b0, 0, 1'b0);

    // 6: reset in the middle of beat 2
    drive_vec(8'h77);
    expect_vec(8'h77);
    step();
    drive_idle();
    step();
    check_beat("t6.b0"); step();
    check_beat("t6.b1"); step();
    chk_s("t6.at_b2", 32'(bus.out_beat_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6.rst");
    exp_q.delete();
    exp_idx_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    drive_vec(8'h99);
    expect_vec(8'h99);
    step();
    drive_idle();
    check_status("t6.entry", 1'b0, 1, 1'b0);
    step();
    for (int k = 0; k < BEATS; k++) begin
      check_beat("t6.after");
      step();
    end
    check_status("t6.done", 1'b0, 0, 1'b0);
    chk_s("t6.sb_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Run-time bound in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of sequence");
    $fatal(1, "watchdog expired");
  end

endmodule
